screen_sequencer: RTL and testbench

Frame-synchronous controller that drives `screen_control`'s `start`, `end_game` and `restart` inputs. It debounces the player buttons and latches the game-over event from game logic. It runs a "get ready" countdown before play starts, enforces a minimum end-screen hold time, and issues every screen-change pulse exactly on a vertical-blank boundary so the display mux never switches mid-frame. It sits between board buttons / game logic and `screen_control`, in the `clk40` domain.

---
 rtl/game_pkg.sv | 26 ++
 rtl/screen_sequencer_btn_debounce.sv | 61 ++++++
 rtl/screen_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_screen_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the screen sequencing logic: state codes,
// default timing for a 40 MHz pixel clock at 60 frames per second,
// and a helper that sizes counters from their terminal count.
package game_pkg;

  // Sequencer state codes, also exported on state_out.
  typedef enum logic [2:0] {
    S_START    = 3'd0,
    S_READY    = 3'd1,
    S_GAME     = 3'd2,
    S_END_LOCK = 3'd3,
    S_END      = 3'd4
  } state_t;

  localparam int CLK_HZ             = 40_000_000;
  localparam int FRAME_RATE         = 60;
  localparam int DEBOUNCE_DEFAULT   = CLK_HZ / 100;   // 10 ms of stable level
  localparam int READY_SECS_DEFAULT = 3;
  localparam int END_HOLD_DEFAULT   = 2 * FRAME_RATE; // two seconds of end screen

  // Counter width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/screen_sequencer_btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter that only
// accepts a new level after it has been seen for CYCLES consecutive
// cycles, and a one-cycle press pulse on the accepted rising edge.
module btn_debounce
  import game_pkg::*;
#(
  parameter int CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk40,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int              CW     = cnt_w(CYCLES);
  localparam logic [CW-1:0]   C_LAST = CW'(CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Bring the raw asynchronous button into the clk40 domain.
  always_ff @(posedge clk40) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive cycles the synchronized input differs from the
  // accepted level; flip the level when the run reaches CYCLES and emit
  // a press only when the new level is high.
  always_ff @(posedge clk40) begin
    if (rst) begin
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_level <= r_sync2;
        r_press <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/screen_sequencer.sv
// Frame-synchronous screen sequencer. Debounces the player buttons,
// latches game-over, runs the get-ready countdown and the end-screen
// hold, and emits start/end_game/restart pulses only in the cycle after
// a vertical-blank rising edge so the display never switches mid-frame.
module screen_sequencer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int FRAMES_PER_SEC  = FRAME_RATE,
  parameter int READY_SECS      = READY_SECS_DEFAULT,
  parameter int END_HOLD_FRAMES = END_HOLD_DEFAULT
) (
  input  logic       clk40,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_restart,
  input  logic       game_over_in,
  input  logic       vblnk_in,
  output logic       start,
  output logic       end_game,
  output logic       restart,
  output logic [2:0] state_out,
  output logic [1:0] countdown_digit
);

  localparam int            FW        = cnt_w(FRAMES_PER_SEC);
  localparam int            HW        = cnt_w(END_HOLD_FRAMES);
  localparam logic [FW-1:0] F_LAST    = FW'(FRAMES_PER_SEC - 1);
  localparam logic [HW-1:0] H_LAST    = HW'(END_HOLD_FRAMES - 1);
  localparam logic [1:0]    SECS_INIT = 2'(READY_SECS);

  logic          w_start_press;
  logic          w_restart_press;
  logic          w_start_level;
  logic          w_restart_level;
  logic          w_unused_levels;
  logic          w_tick;
  logic          w_take_start;
  logic          w_take_end;
  logic          w_take_restart;

  logic          r_vblnk_d;
  logic          r_pend_start;
  logic          r_pend_end;
  logic          r_pend_restart;
  state_t        r_state;
  logic [FW-1:0] r_fcnt;
  logic [HW-1:0] r_hcnt;
  logic [1:0]    r_secs;
  logic          r_start;
  logic          r_end_game;
  logic          r_restart;

  btn_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db_start (
    .clk40  (clk40),
    .rst    (rst),
    .btn_in (btn_start),
    .level  (w_start_level),
    .press  (w_start_press)
  );

  btn_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_db_restart (
    .clk40  (clk40),
    .rst    (rst),
    .btn_in (btn_restart),
    .level  (w_restart_level),
    .press  (w_restart_press)
  );

  // Debounced levels are not needed here; only the press pulses drive the FSM.
  assign w_unused_levels = w_start_level ^ w_restart_level;

  // Delayed vblank; held high in reset so a blank already in progress
  // when reset releases does not look like a new frame.
  always_ff @(posedge clk40) begin
    if (rst) begin
      r_vblnk_d <= 1'b1;
    end else begin
      r_vblnk_d <= vblnk_in;
    end
  end

  assign w_tick = vblnk_in & ~r_vblnk_d;

  // A pending request is served only on a tick and only from its state.
  assign w_take_start   = w_tick && (r_state == S_START) && r_pend_start;
  assign w_take_end     = w_tick && (r_state == S_GAME)  && r_pend_end;
  assign w_take_restart = w_tick && (r_state == S_END)   && r_pend_restart;

  // Pending flags: latch a request only in the state that can use it,
  // clear it on the tick that serves it (clear beats a same-cycle set so
  // a level-held game_over cannot re-arm after being served).
  always_ff @(posedge clk40) begin
    if (rst) begin
      r_pend_start   <= 1'b0;
      r_pend_end     <= 1'b0;
      r_pend_restart <= 1'b0;
    end else begin
      if (w_take_start) begin
        r_pend_start <= 1'b0;
      end else if (w_start_press && (r_state == S_START)) begin
        r_pend_start <= 1'b1;
      end

      if (w_take_end) begin
        r_pend_end <= 1'b0;
      end else if (game_over_in && (r_state == S_GAME)) begin
        r_pend_end <= 1'b1;
      end

      if (w_take_restart) begin
        r_pend_restart <= 1'b0;
      end else if (w_restart_press && (r_state == S_END)) begin
        r_pend_restart <= 1'b1;
      end
    end
  end

  // Sequencer FSM with frame/second/hold counters and registered pulses.
  // r_secs doubles as the countdown digit and is kept at 0 outside READY.
  always_ff @(posedge clk40) begin
    if (rst) begin
      r_state    <= S_START;
      r_fcnt     <= '0;
      r_hcnt     <= '0;
      r_secs     <= 2'd0;
      r_start    <= 1'b0;
      r_end_game <= 1'b0;
      r_restart  <= 1'b0;
    end else begin
      r_start    <= 1'b0;
      r_end_game <= 1'b0;
      r_restart  <= 1'b0;
      case (r_state)
        S_START: begin
          if (w_take_start) begin
            r_state <= S_READY;
            r_fcnt  <= '0;
            r_secs  <= SECS_INIT;
          end
        end
        S_READY: begin
          if (w_tick) begin
            if (r_fcnt == F_LAST) begin
              r_fcnt <= '0;
              if (r_secs == 2'd1) begin
                r_start <= 1'b1;
                r_state <= S_GAME;
                r_secs  <= 2'd0;
              end else begin
                r_secs <= r_secs - 2'd1;
              end
            end else begin
              r_fcnt <= r_fcnt + 1'b1;
            end
          end
        end
        S_GAME: begin
          if (w_take_end) begin
            r_end_game <= 1'b1;
            r_state    <= S_END_LOCK;
            r_hcnt     <= '0;
          end
        end
        S_END_LOCK: begin
          if (w_tick) begin
            if (r_hcnt == H_LAST) begin
              r_state <= S_END;
            end else begin
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
        end
        S_END: begin
          if (w_take_restart) begin
            r_restart <= 1'b1;
            r_state   <= S_START;
          end
        end
        default: begin
          r_state <= S_START;
          r_secs  <= 2'd0;
        end
      endcase
    end
  end

  assign start           = r_start;
  assign end_game        = r_end_game;
  assign restart         = r_restart;
  assign state_out       = r_state;
  assign countdown_digit = r_secs;

endmodule

// File: tb/tb_screen_sequencer.sv
// Randomized bench for screen_sequencer. The stimulus process drives
// frames, buttons, game-over and resets, and runs a tick-level reference
// model that pushes each expected pulse into a scoreboard queue. A
// separate monitor compares state/digit every cycle and pops the queue
// whenever the DUT shows a pulse.
module tb_screen_sequencer;

  localparam int DEB = 4;
  localparam int FPS = 2;
  localparam int RS  = 3;
  localparam int EH  = 2;
  localparam int FRAME = 40;
  localparam int VB    = 8;

  localparam int C_START = 0;
  localparam int C_READY = 1;
  localparam int C_GAME  = 2;
  localparam int C_LOCK  = 3;
  localparam int C_END   = 4;

  localparam int K_START   = 0;
  localparam int K_END     = 1;
  localparam int K_RESTART = 2;

  logic       clk40 = 1'b0;
  logic       rst = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_restart = 1'b0;
  logic       game_over_in = 1'b0;
  logic       vblnk_in = 1'b1;
  logic       start;
  logic       end_game;
  logic       restart;
  logic [2:0] state_out;
  logic [1:0] countdown_digit;

  screen_sequencer #(
    .DEBOUNCE_CYCLES (DEB),
    .FRAMES_PER_SEC  (FPS),
    .READY_SECS      (RS),
    .END_HOLD_FRAMES (EH)
  ) dut (
    .clk40           (clk40),
    .rst             (rst),
    .btn_start       (btn_start),
    .btn_restart     (btn_restart),
    .game_over_in    (game_over_in),
    .vblnk_in        (vblnk_in),
    .start           (start),
    .end_game        (end_game),
    .restart         (restart),
    .state_out       (state_out),
    .countdown_digit (countdown_digit)
  );

  always #5 clk40 = ~clk40;

  typedef struct {
    int kind;
    int st;
    int due;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   done = 1'b0;

  // Reference model, tracked in ticks rather than registers.
  int m_state = C_START;
  int ready_ticks = 0;
  int lock_ticks = 0;
  bit pend_s = 1'b0;
  bit pend_e = 1'b0;
  bit pend_r = 1'b0;
  bit m_vd = 1'b1;
  int games = 0;

  function automatic int m_digit();
    return (m_state == C_READY) ? (RS - ready_ticks / FPS) : 0;
  endfunction

  task automatic push_exp(input int kind);
    exp_t e;
    e.kind = kind;
    e.st   = m_state;
    e.due  = cyc;
    sb_q.push_back(e);
  endtask

  // Advance the model by one clock edge using the inputs sampled at it.
  task automatic model_step();
    bit tick;
    bit served;
    int old;
    if (rst) begin
      m_state = C_START;
      pend_s = 0; pend_e = 0; pend_r = 0;
      ready_ticks = 0; lock_ticks = 0;
      m_vd = 1'b1;
      return;
    end
    tick   = vblnk_in && !m_vd;
    m_vd   = vblnk_in;
    old    = m_state;
    served = 1'b0;
    if (tick) begin
      case (m_state)
        C_START: if (pend_s) begin
          pend_s = 0; m_state = C_READY; ready_ticks = 0;
        end
        C_READY: begin
          ready_ticks++;
          if (ready_ticks == RS * FPS) begin
            m_state = C_GAME; push_exp(K_START);
          end
        end
        C_GAME: if (pend_e) begin
          pend_e = 0; served = 1'b1; m_state = C_LOCK; lock_ticks = 0;
          push_exp(K_END);
        end
        C_LOCK: begin
          lock_ticks++;
          if (lock_ticks == EH) m_state = C_END;
        end
        C_END: if (pend_r) begin
          pend_r = 0; m_state = C_START; games++;
          push_exp(K_RESTART);
        end
        default: ;
      endcase
    end
    if (game_over_in && (old == C_GAME) && !served) pend_e = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  int pos = 3;
  int st_cnt = 0, rs_cnt = 0, go_cnt = 0, rst_cnt = 0;
  int p_btn = 0, p_pos = -1, p_len = 0;
  bit p_long = 1'b0;
  int p_go_pos = -1, p_go_len = 0;
  bit p_go_tick = 1'b0;
  int p_rst_pos = -1;
  int start_plans = 0, game_plans = 0;
  bit did_reset = 1'b0;

  task automatic plan_press(input int btn, input bit lng);
    p_btn  = btn;
    p_long = lng;
    p_pos  = int'($urandom_range(10, 18));
    p_len  = lng ? int'($urandom_range(6, 12)) : int'($urandom_range(1, 3));
  endtask

  task automatic plan_go(input int mode);
    case (mode)
      1: p_go_tick = 1'b1;
      2: begin p_go_pos = int'($urandom_range(5, 35)); p_go_len = 1; end
      3: begin p_go_pos = 15; p_go_len = int'($urandom_range(20, 60)); end
      default: ;
    endcase
  endtask

  // Decide this frame's events right after the tick has been modelled.
  task automatic make_plan();
    p_btn = 0; p_pos = -1; p_go_pos = -1; p_rst_pos = -1;
    case (m_state)
      C_START: begin
        if (start_plans == 0) begin
          p_btn = 1; p_long = 1'b0; p_pos = 10; p_len = 3;
        end else if (start_plans == 1) begin
          p_btn = 1; p_long = 1'b1; p_pos = 12; p_len = 10;
        end else begin
          plan_press(1, ($urandom_range(0, 3) != 0));
        end
        start_plans++;
        if ($urandom_range(0, 1) == 1) begin p_go_pos = 30; p_go_len = 1; end
      end
      C_READY: begin
        if (!did_reset && ready_ticks == 2) begin
          p_rst_pos = 20; did_reset = 1'b1;
        end else begin
          case ($urandom_range(0, 2))
            0: plan_press(1, 1'b1);
            1: plan_go(2);
            default: ;
          endcase
        end
      end
      C_GAME: begin
        if (!pend_e) begin
          if (game_plans < 3) plan_go(game_plans + 1);
          else plan_go(int'($urandom_range(0, 3)));
          game_plans++;
        end
      end
      C_LOCK: begin
        p_btn = 2; p_long = 1'b1; p_pos = 10; p_len = 12;
      end
      C_END: plan_press(2, ($urandom_range(0, 3) != 0));
      default: ;
    endcase
  endtask

  task automatic run_cycle();
    @(posedge clk40);
    cyc++;
    model_step();
    #1;
    if (st_cnt > 0) st_cnt--;
    if (rs_cnt > 0) rs_cnt--;
    if (go_cnt > 0) go_cnt--;
    if (rst_cnt > 0) rst_cnt--;
    pos = (pos + 1) % FRAME;
    if (pos == 1) make_plan();
    if (pos == 0 && p_go_tick) begin go_cnt = 1; p_go_tick = 1'b0; end
    if (pos == p_go_pos) go_cnt = p_go_len;
    if (pos == p_pos) begin
      if (p_btn == 1) begin
        st_cnt = p_len;
        if (p_long && m_state == C_START) pend_s = 1'b1;
      end else if (p_btn == 2) begin
        rs_cnt = p_len;
        if (p_long && m_state == C_END) pend_r = 1'b1;
      end
    end
    if (pos == p_rst_pos) rst_cnt = 3;
    btn_start    = (st_cnt > 0);
    btn_restart  = (rs_cnt > 0);
    game_over_in = (go_cnt > 0);
    rst          = (rst_cnt > 0);
    vblnk_in     = (pos < VB);
  endtask

  initial begin
    rst = 1'b1;
    vblnk_in = 1'b1;
    repeat (6) begin
      @(posedge clk40);
      cyc++;
      model_step();
      #1;
    end
    rst = 1'b0;
    for (int c = 0; c < 600 * FRAME && games < 5; c++) run_cycle();
    repeat (3) run_cycle();
    done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic check(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
    end
  endtask

  initial begin
    exp_t e;
    int   npulse;
    int   kind;
    forever begin
      @(negedge clk40);
      if (done) break;
      check("state_out", int'(state_out), m_state);
      check("countdown_digit", int'(countdown_digit), m_digit());
      npulse = int'(start) + int'(end_game) + int'(restart);
      if (npulse > 1) check("one_pulse_per_cycle", npulse, 1);
      while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        e = sb_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missing_pulse kind %0d due cycle %0d: got none by cycle %0d", e.kind, e.due, cyc);
      end
      if (npulse >= 1) begin
        kind = start ? K_START : (end_game ? K_END : K_RESTART);
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pulse at cycle %0d: got kind %0d, expected no pulse", cyc, kind);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind", kind, e.kind);
          check("pulse_cycle", cyc, e.due);
          check("pulse_state", int'(state_out), e.st);
        end
      end
    end
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missing_pulse kind %0d due cycle %0d: got none before end", e.kind, e.due);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
